project01: RTL and testbench

PROJECT01 -- requirements
Module: project01

---
 rtl/project01_pkg.sv | 14 +
 rtl/project01_bitcmp.sv | 12 +
 rtl/project01.sv | 111 +++++++++++
 tb/tb_project01.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/project01_pkg.sv
// Shared types and constants for the project01 serial magnitude comparator.
package project01_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPARE = 2'd1,
    DONE    = 2'd2
  } state_t;

  localparam logic [1:0] RES_EQ = 2'b00;
  localparam logic [1:0] RES_GT = 2'b01;
  localparam logic [1:0] RES_LT = 2'b10;

endpackage

// File: rtl/project01_bitcmp.sv
// Combinational single-bit magnitude compare used by the project01 walker.
module project01_bitcmp (
  input  logic a_i,
  input  logic b_i,
  output logic gt_o,
  output logic lt_o
);

  assign gt_o = a_i & ~b_i;
  assign lt_o = ~a_i & b_i;

endmodule

// File: rtl/project01.sv
// Serial MSB-first magnitude comparator, one bit pair per cycle.
// Optional macro PROJECT01_SIGNED_EN selects two's-complement comparison.
module project01
  import project01_pkg::*;
#(
  parameter int WIDTH = 5
) (
  output logic [1:0]       r,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             busy,
  output logic             done
);

  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IDX_W-1:0] IDX_MSB = IDX_W'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [1:0]       res_q, res_d;
  logic [1:0]       r_q, r_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] a_cap, b_cap;
  logic             bit_gt, bit_lt;

`ifdef PROJECT01_SIGNED_EN
  // Flipping the sign bit maps two's-complement order onto unsigned order.
  assign a_cap = {~a[WIDTH-1], a[WIDTH-2:0]};
  assign b_cap = {~b[WIDTH-1], b[WIDTH-2:0]};
`else
  assign a_cap = a;
  assign b_cap = b;
`endif

  project01_bitcmp u_bitcmp (
    .a_i  (a_q[idx_q]),
    .b_i  (b_q[idx_q]),
    .gt_o (bit_gt),
    .lt_o (bit_lt)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    idx_d   = idx_q;
    res_d   = res_q;
    r_d     = r_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = a_cap;
          b_d     = b_cap;
          idx_d   = IDX_MSB;
          state_d = COMPARE;
        end
      end
      COMPARE: begin
        if (bit_gt) begin
          res_d   = RES_GT;
          state_d = DONE;
        end else if (bit_lt) begin
          res_d   = RES_LT;
          state_d = DONE;
        end else if (idx_q == '0) begin
          res_d   = RES_EQ;
          state_d = DONE;
        end else begin
          idx_d = idx_q - IDX_W'(1);
        end
      end
      DONE: begin
        // r and done are registered here, giving N+1 cycles start-to-done.
        r_d     = res_q;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      idx_q   <= '0;
      res_q   <= RES_EQ;
      r_q     <= RES_EQ;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      idx_q   <= idx_d;
      res_q   <= res_d;
      r_q     <= r_d;
      done_q  <= done_d;
    end
  end

  assign r    = r_q;
  assign done = done_q;
  assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_project01.sv
// Scoreboard bench for project01: expected results queued at start, checked at done.
module tb_project01;

  localparam int W = 5;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a, b;
  logic [1:0]   r;
  logic         busy, done;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [1:0]   r;
    int           lat;
    logic [W-1:0] a;
    logic [W-1:0] b;
  } exp_t;

  exp_t sb[$];

  project01 #(.WIDTH(W)) dut (
    .r     (r),
    .a     (a),
    .b     (b),
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .busy  (busy),
    .done  (done)
  );

  always #5 clk = ~clk;

  // Reference: relational compare for r, first differing bit from MSB for latency.
  function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t e;
    e.a = x;
    e.b = y;
`ifdef PROJECT01_SIGNED_EN
    if ($signed(x) > $signed(y))      e.r = 2'b01;
    else if ($signed(x) < $signed(y)) e.r = 2'b10;
    else                              e.r = 2'b00;
`else
    if (x > y)      e.r = 2'b01;
    else if (x < y) e.r = 2'b10;
    else            e.r = 2'b00;
`endif
    e.lat = W + 1;
    for (int i = W - 1; i >= 0; i--) begin
      if (x[i] !== y[i]) begin
        e.lat = W - i + 1;
        break;
      end
    end
    return e;
  endfunction

  // Called at a negedge; returns at the negedge after the start edge (cycle 0).
  task automatic drive_start(input logic [W-1:0] x, input logic [W-1:0] y, input bit push);
    a     = x;
    b     = y;
    start = 1'b1;
    if (push) sb.push_back(model(x, y));
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    // Scramble the operand inputs after capture; the result must not move.
    a = ~x;
    b = ~y;
  endtask

  task automatic wait_done(output int lat, output bit timeout);
    lat     = 0;
    timeout = 1'b1;
    for (int c = 1; c <= W + 4; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (done === 1'b1) begin
        lat     = c;
        timeout = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    a     = '0;
    b     = '0;
    repeat (2) @(negedge clk);
    tests++;
    if (r !== 2'b00) begin fails++; $display("FAIL reset_r: got %b want 00", r); end
    tests++;
    if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", busy); end
    tests++;
    if (done !== 1'b0) begin fails++; $display("FAIL reset_done: got %b want 0", done); end
    rst_n = 1'b1;
    @(negedge clk);
    $display("[TB] reset: r=%b busy=%b done=%b", r, busy, done);
  endtask

  task automatic test_compare();
    logic [W-1:0] xs[$];
    logic [W-1:0] ys[$];
    int  lat;
    bit  to;
    exp_t e;
    xs = '{5'b00000, 5'b00010, 5'b00001, 5'b01011, 5'b00111, 5'b11111, 5'b10000};
    ys = '{5'b00000, 5'b00001, 5'b00010, 5'b01011, 5'b01010, 5'b11110, 5'b00001};
    for (int k = 0; k < 4; k++) begin
      xs.push_back(W'($urandom_range(0, 31)));
      ys.push_back(W'($urandom_range(0, 31)));
    end
    foreach (xs[i]) begin
      drive_start(xs[i], ys[i], 1'b1);
      tests++;
      if (busy !== 1'b1) begin fails++; $display("FAIL cmp_busy[%0d]: got %b want 1", i, busy); end
      wait_done(lat, to);
      e = sb.pop_front();
      tests++;
      if (to) begin
        fails++;
        $display("FAIL cmp_timeout[%0d]: a=%b b=%b no done within %0d cycles", i, e.a, e.b, W + 4);
      end else begin
        if (lat !== e.lat) begin fails++; $display("FAIL cmp_lat[%0d]: got %0d want %0d", i, lat, e.lat); end
        tests++;
        if (r !== e.r) begin fails++; $display("FAIL cmp_r[%0d]: a=%b b=%b got %b want %b", i, e.a, e.b, r, e.r); end
        tests++;
        if (busy !== 1'b0) begin fails++; $display("FAIL cmp_busy_done[%0d]: got %b want 0", i, busy); end
      end
      @(negedge clk);
      tests++;
      if (done !== 1'b0 || r !== e.r) begin
        fails++;
        $display("FAIL cmp_hold[%0d]: done=%b r=%b want done=0 r=%b", i, done, r, e.r);
      end
      $display("[TB] compare a=%b b=%b -> r=%b lat=%0d (want %b/%0d)", e.a, e.b, r, lat, e.r, e.lat);
    end
  endtask

  task automatic test_reset_abort();
    int  lat;
    bit  to;
    int  seen;
    exp_t e;
    drive_start(5'b01110, 5'b01110, 1'b0);
    repeat (2) begin @(posedge clk); @(negedge clk); end
    rst_n = 1'b0;
    #1;
    tests++;
    if (r !== 2'b00 || busy !== 1'b0 || done !== 1'b0) begin
      fails++;
      $display("FAIL abort_async: r=%b busy=%b done=%b want 00/0/0", r, busy, done);
    end
    seen = 0;
    for (int c = 0; c < W + 3; c++) begin
      @(negedge clk);
      if (done === 1'b1) seen++;
    end
    rst_n = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      if (done === 1'b1) seen++;
    end
    tests++;
    if (seen != 0) begin fails++; $display("FAIL abort_no_done: got %0d pulses want 0", seen); end
    drive_start(5'b01110, 5'b01110, 1'b1);
    wait_done(lat, to);
    e = sb.pop_front();
    tests++;
    if (to || lat !== e.lat || r !== e.r) begin
      fails++;
      $display("FAIL abort_restart: timeout=%0d lat=%0d r=%b want lat=%0d r=%b", to, lat, r, e.lat, e.r);
    end
    $display("[TB] reset_abort: restart r=%b lat=%0d", r, lat);
  endtask

  task automatic test_busy_ignore();
    int  lat;
    bit  to;
    int  extra;
    exp_t e;
    @(negedge clk);
    drive_start(5'b00001, 5'b00011, 1'b1);
    lat = 0;
    to  = 1'b1;
    // Hold a competing start with opposite-ordered operands through COMPARE and DONE.
    for (int c = 1; c <= W + 4; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (done === 1'b1) begin
        lat   = c;
        to    = 1'b0;
        start = 1'b0;
        break;
      end
      a     = 5'b11111;
      b     = 5'b00000;
      start = 1'b1;
    end
    start = 1'b0;
    e = sb.pop_front();
    tests++;
    if (to || lat !== e.lat || r !== e.r) begin
      fails++;
      $display("FAIL busy_ignore: timeout=%0d lat=%0d r=%b want lat=%0d r=%b", to, lat, r, e.lat, e.r);
    end
    extra = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (busy === 1'b1 || done === 1'b1) extra++;
    end
    tests++;
    if (extra != 0) begin fails++; $display("FAIL busy_ignore_after: got %0d active cycles want 0", extra); end
    $display("[TB] busy_ignore: r=%b lat=%0d (want %b/%0d)", r, lat, e.r, e.lat);
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] xs[3];
    logic [W-1:0] ys[3];
    int  lat;
    bit  to;
    exp_t e;
    xs = '{5'b11000, 5'b00100, 5'b10101};
    ys = '{5'b10000, 5'b00110, 5'b10101};
    for (int i = 0; i < 3; i++) begin
      // Start issued in the done-pulse cycle, when the FSM is already in IDLE.
      drive_start(xs[i], ys[i], 1'b1);
      wait_done(lat, to);
      e = sb.pop_front();
      tests++;
      if (to || lat !== e.lat || r !== e.r) begin
        fails++;
        $display("FAIL b2b[%0d]: timeout=%0d lat=%0d r=%b want lat=%0d r=%b", i, to, lat, r, e.lat, e.r);
      end
      $display("[TB] b2b a=%b b=%b -> r=%b lat=%0d", e.a, e.b, r, lat);
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_compare();
    test_reset_abort();
    test_busy_ignore();
    test_back_to_back();
    tests++;
    if (sb.size() != 0) begin fails++; $display("FAIL sb_empty: got %0d left want 0", sb.size()); end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
